// File: rtl/booth4_mult_seq_ctrl.sv
// booth4_mult_seq_ctrl
// Sequential radix-4 Booth signed multiplier. Each CALC cycle retires one
// Booth digit (two multiplier bits) and accumulates its partial product into
// a 2*WIDTH-bit accumulator. The upstream and downstream sides each use a
// valid/ready handshake.
//
// Optional feature macro: BOOTH_EARLY_TERM_EN
//   When it is defined, CALC ends as soon as the remaining multiplier bits are
//   all 0s or all 1s, because every digit still to come would be zero.
//   When it is undefined, CALC always runs for WIDTH/2 cycles.
module booth4_mult_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int ITER = WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // The multiplicand is pre-shifted by 2 bits each iteration, so it already
  // carries the 4^i weight. The multiplier holds {b, b[-1]} and is
  // arithmetic-shifted right by 2, so the current Booth window is always
  // bits [2:0].
  logic signed [PW-1:0]  mcand_sh;
  logic signed [WIDTH:0] mplier_sh;
  logic signed [PW-1:0]  acc;
  logic signed [PW-1:0]  pp;
  logic signed [PW-1:0]  acc_sum;
  logic [CNT_W-1:0]      cnt;
  logic [PW-1:0]         product_r;
  logic                  last_iter;
  logic                  done_iter;

  // Map a Booth window {b[2i+1], b[2i], b[2i-1]} to its partial product.
  function automatic logic signed [PW-1:0] booth_pp(input logic [2:0] win,
                                                    input logic signed [PW-1:0] m);
    logic signed [PW-1:0] r;
    case (win)
      3'b001, 3'b010: r = m;
      3'b011:         r = m <<< 1;
      3'b100:         r = -(m <<< 1);
      3'b101, 3'b110: r = -m;
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign pp        = booth_pp(mplier_sh[2:0], mcand_sh);
  assign acc_sum   = acc + pp;
  assign last_iter = (cnt == CNT_W'(ITER - 1));
`ifdef BOOTH_EARLY_TERM_EN
  // The shifted multiplier sign-extends b[WIDTH-1]. If it is uniform, every
  // remaining window is 000 or 111.
  assign done_iter = last_iter || (mplier_sh == '0) || (mplier_sh == '1);
`else
  assign done_iter = last_iter;
`endif
  assign product   = product_r;

  // State register. An asynchronous reset aborts any operation in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and handshake outputs. An unencoded state falls back to IDLE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (done_iter) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Capture operands on accept, step one digit per CALC cycle, and
  // publish the product only on the final iteration.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mcand_sh  <= '0;
      mplier_sh <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand_sh  <= {{WIDTH{a[WIDTH-1]}}, a};
            mplier_sh <= {b, 1'b0};
            acc       <= '0;
            cnt       <= '0;
          end
        end
        CALC: begin
          acc       <= acc_sum;
          mcand_sh  <= mcand_sh <<< 2;
          mplier_sh <= mplier_sh >>> 2;
          cnt       <= cnt + 1'b1;
          if (done_iter) product_r <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_mult_seq_ctrl.sv
// Testbench for booth4_mult_seq_ctrl: directed corner cases, back-pressure,
// reset abort, and a randomized signed soak against a plain a*b reference.
module tb_booth4_mult_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int PW    = 2 * WIDTH;
  localparam int SOAK  = 5000;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    product;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  booth4_mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference product: plain signed multiplication, truncated to PW bits.
  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic signed [PW-1:0] r;
    r = $signed(x) * $signed(y);
    return r;
  endfunction

  // Expected latency, counted as the cycle index at which out_valid is seen
  // (the cycle just after the accept edge is cycle 1).
  function automatic int exp_lat(input logic [WIDTH-1:0] y);
`ifdef BOOTH_EARLY_TERM_EN
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] rem;
    ext = {y, 1'b0};
    for (int i = 0; i < WIDTH / 2; i++) begin
      rem = ext >>> (2 * i);
      if (rem == '0 || rem == '1) return i + 2;
    end
`endif
    return WIDTH / 2 + 1;
  endfunction

  task automatic do_mult(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                         input logic [PW-1:0] want, input int stall, input bit wiggle,
                         input string tag);
    int lat;
    bit ctl_bad;
    bit ok;
    lat = 0;
    ctl_bad = 1'b0;
    ok = 1'b0;
    @(negedge sys_clk);
    for (int k = 0; k < 40 && !in_ready; k++) @(negedge sys_clk);
    if (!in_ready) begin
      chk({tag, "_accept_timeout"}, 64'(in_ready), 64'(1));
      return;
    end
    a = aa;
    b = bb;
    in_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    for (int k = 0; k < 40; k++) begin
      @(negedge sys_clk);
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      if (in_ready || !busy) ctl_bad = 1'b1;
    end
    if (!ok) begin
      chk({tag, "_done_timeout"}, 64'(out_valid), 64'(1));
      return;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(bb)));
    chk({tag, "_calc_ctl"}, 64'(ctl_bad), 64'(0));
    chk({tag, "_done_ctl"}, 64'({in_ready, busy}), 64'(2'b01));
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_hold_prod"}, 64'(product), 64'(want));
      chk({tag, "_hold_ov"}, 64'(out_valid), 64'(1));
      if (wiggle) begin
        in_valid = ~in_valid;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      @(negedge sys_clk);
    end
    in_valid = 1'b0;
    chk({tag, "_prod"}, 64'(product), 64'(want));
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 64'(out_valid), 64'(0));
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    logic [WIDTH-1:0] corners [5];
    corners[0] = 16'h8000;
    corners[1] = 16'h7FFF;
    corners[2] = 16'hFFFF;
    corners[3] = 16'h0000;
    corners[4] = 16'h0001;
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
    return WIDTH'($urandom);
  endfunction

  initial begin
    bit ov_seen;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_ctl", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    chk("rst_prod", 64'(product), 64'(0));
    @(negedge sys_clk);
    sys_rst = 1'b0;

    do_mult(16'd3, 16'd5, 32'h0000000F, 0, 1'b0, "a3b5");
    do_mult(16'h8000, 16'h8000, 32'h40000000, 0, 1'b0, "minmin");
    do_mult(16'h7FFF, 16'h8000, 32'hC0008000, 0, 1'b0, "maxmin");
    do_mult(16'hFFFF, 16'h0001, 32'hFFFFFFFF, 0, 1'b0, "m1x1");
    do_mult(16'hFFF9, 16'h0009, 32'hFFFFFFC1, 5, 1'b1, "bp");
    do_mult(16'h1234, 16'h0001, 32'h00001234, 0, 1'b0, "b_one");
    do_mult(16'h0003, 16'h7FFF, 32'h00017FFD, 0, 1'b0, "b_max");
    do_mult(16'h0005, 16'h0000, 32'h00000000, 0, 1'b0, "b_zero");
    do_mult(16'h0005, 16'hFFFF, 32'hFFFFFFFB, 0, 1'b0, "b_m1");

    // Abort in the middle of CALC with an asynchronous reset.
    @(negedge sys_clk);
    a = 16'd1234;
    b = 16'd567;
    in_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("abort_ctl", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    chk("abort_prod", 64'(product), 64'(0));
    @(negedge sys_clk);
    sys_rst = 1'b0;
    ov_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      if (out_valid) ov_seen = 1'b1;
    end
    chk("abort_no_ov", 64'(ov_seen), 64'(0));
    do_mult(16'd2, 16'hFFFD, 32'hFFFFFFFA, 0, 1'b0, "post_abort");

    for (int n = 0; n < SOAK; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      do_mult(ra, rb, ref_mul(ra, rb), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
              1'($urandom_range(0, 1)), "soak");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
